axi_mm2s_dma: RTL and testbench
===============================

// Module: axi_mm2s_dma
// PURPOSE
//  Read-DMA master: takes {addr, beats} commands, issues AXI4 INCR read bursts on an M_AXI port
//  (the DDR-model memory side of the testbench/SoC), streams returned data out as AXI-Stream with
//  TLAST on the final beat. Feeds the systolic array's input AXIS ports from memory.
// PARAMETERS
//  DATA_WIDTH      128   AXI/AXIS data width (bits); BYTES=DATA_WIDTH/8, LSB=$clog2(BYTES)
//  ADDR_WIDTH      32    AXI address width
//  ID_WIDTH        6     ARID width; ARID driven constant ID_VALUE
//  ID_VALUE        0     ARID value
//  MAX_BURST       16    max beats per AR burst (1..256, power of 2)
//  MAX_OUTSTANDING 4     max ARs issued whose final R beat is not yet accepted
//  BEATS_WIDTH     24    width of cmd_beats
// PORTS
//  clk            in   1            clock
//  rstn           in   1            async active-low reset
//  cmd_valid      in   1            command valid
//  cmd_ready      out  1            high only in IDLE
//  cmd_addr       in   ADDR_WIDTH   start byte address; low LSB bits ignored (treated 0)
//  cmd_beats      in   BEATS_WIDTH  beat count; 0 = no-op
//  busy           out  1            high when not IDLE
//  done           out  1            1-cycle pulse after final AXIS beat accepted (or for beats=0)
//  err            out  1            sticky: any RRESP!=OKAY since last accepted command
//  m_axi_arid/araddr/arlen/arsize/arburst  out  ID/ADDR/8/3/2  read address channel
//  m_axi_arlock/arcache/arprot  out  1/4/3   constant 0/4'b0011/3'b000
//  m_axi_arvalid  out  1  ;  m_axi_arready  in  1
//  m_axi_rid/rdata/rresp/rlast/rvalid  in  ID/DATA/2/1/1   read data channel
//  m_axi_rready   out  1            read data ready (= skid buffer ready)
//  m_axis_tdata   out  DATA_WIDTH   stream data
//  m_axis_tvalid  out  1  ;  m_axis_tready  in  1
//  m_axis_tlast   out  1            high on beat cmd_beats-1 of current command
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; err 0. cmd_ready=1 the first cycle after reset.
//  Reset mid-operation: abort immediately; in-flight ARs/R beats abandoned (memory side reset too).
//  States: IDLE -> (cmd_valid&&beats!=0) ADDR; IDLE -> (cmd_valid&&beats==0) done pulse next cycle.
//   ADDR: issue bursts until ar_rem==0 -> DRAIN. DRAIN: when out_rem==0 -> IDLE, pulse done.
//  Command accept clears err, latches addr (aligned), ar_rem=out_rem=beats.
//  Burst sizing: len_beats = min(ar_rem, MAX_BURST, (4096-addr[11:0])>>LSB); never crosses 4KB.
//   ARLEN=len_beats-1, ARSIZE=LSB, ARBURST=INCR. After AR handshake: addr+=len_beats<<LSB,
//   ar_rem-=len_beats, outstanding++.
//  AR rules: ARVALID held with stable payload until ARREADY; ARVALID asserted only if
//   outstanding<MAX_OUTSTANDING (checked before raising, never dropped once raised).
//  R path: R beat -> skid buffer -> AXIS. RREADY = skid ready; no combinational path tready->rready.
//   RLAST accepted -> outstanding--; simultaneous AR handshake and RLAST: net unchanged.
//  AXIS: tdata=rdata; tlast=(out_rem==1) at beat; out_rem-- per tvalid&&tready. TVALID never
//   drops without TREADY; payload stable while stalled. Full-throughput: 1 beat/clk when unstalled.
//  Latency: cmd accept -> ARVALID 1 clk; R beat -> TVALID 1 clk.
//  err set on any accepted R beat with RRESP!=0; data still forwarded. RID ignored.
//  Counter widths: ar_rem/out_rem BEATS_WIDTH; outstanding $clog2(MAX_OUTSTANDING+1).
// STRUCTURE
//  Package dma_pkg: state enum {IDLE,ADDR,DRAIN}, AXI burst/resp localparams (INCR, OKAY),
//   function burst_beats(addr,rem,max,lsb) shared with the future S2MM write DMA.
//  Sub-module axis_skid_buf #(WIDTH): 2-entry registered valid/ready skid buffer (data+last).
//  Top holds FSM, AR generator, counters.
// TESTING (DATA_WIDTH=128, MAX_BURST=16, memory model with random ready/valid throttle)
//  addr=0x1000, beats=40, tready=1 -> ARs len 15,15,7 at 0x1000/0x1100/0x1200; 40 beats in order,
//   tlast on beat 39 only; done 1 pulse; err=0.
//  addr=0x1FC0, beats=8 -> AR len 3 @0x1FC0, AR len 3 @0x2000 (4KB split); 8 correct beats.
//  beats=0 -> no AR, no AXIS beat, done pulse 1 clk after accept, cmd_ready back next cycle.
//  beats=200, tready toggling 30%, arready 50% -> outstanding never >4, no beat lost/duplicated,
//   TVALID/TDATA stable while stalled.
//  memory returns RRESP=2'b10 on beat 5 of beats=16 -> err=1 sticky, 16 beats forwarded; next cmd clears.
//  rstn pulled low mid-burst (beat 10 of 64) -> all outputs 0 async; new cmd after reset runs cleanly.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the AXI DMA engines: FSM states, AXI encodings and
// the 4KB-safe burst sizing used by both read and write directions.
package dma_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DRAIN} state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Beats in the next burst: limited by what is left, the burst cap and the
  // distance to the next 4KB boundary (addr is assumed beat-aligned).
  function automatic logic [8:0] burst_beats(input logic [11:0] addr,
                                             input logic [31:0] rem,
                                             input logic [8:0]  max,
                                             input int unsigned lsb);
    logic [12:0] to_4k;
    logic [31:0] n;
    to_4k = (13'h1000 - {1'b0, addr}) >> lsb;
    n = rem;
    if (n > {23'd0, max})   n = {23'd0, max};
    if (n > {19'd0, to_4k}) n = {19'd0, to_4k};
    return n[8:0];
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer: breaks the ready path so the upstream
// ready is a flop, while still sustaining one beat per clock.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] sk_data;
  logic             sk_vld;

  assign s_ready = !sk_vld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      sk_data <= '0;
      sk_vld  <= 1'b0;
    end else if (!m_valid || m_ready) begin
      if (sk_vld) begin
        m_data  <= sk_data;
        m_valid <= 1'b1;
        sk_vld  <= 1'b0;
      end else begin
        m_valid <= s_valid;
        if (s_valid) m_data <= s_data;
      end
    end else if (s_valid && !sk_vld) begin
      // output stalled: park the incoming beat, which drops s_ready next cycle
      sk_data <= s_data;
      sk_vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_mm2s_dma.sv
// Read DMA: turns {addr, beats} commands into 4KB-safe AXI4 INCR read bursts
// and streams the returned data out on AXI-Stream with TLAST on the last beat.
module axi_mm2s_dma
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 6,
  parameter int ID_VALUE        = 0,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BEATS_WIDTH     = 24
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [BEATS_WIDTH-1:0] cmd_beats,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ID_WIDTH-1:0]    m_axi_arid,
  output logic [ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arlock,
  output logic [3:0]             m_axi_arcache,
  output logic [2:0]             m_axi_arprot,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [ID_WIDTH-1:0]    m_axi_rid,
  input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  state_t                 state, state_nx;
  logic                   alive, done_nx;
  logic [ADDR_WIDTH-1:0]  addr_q, src_addr;
  logic [BEATS_WIDTH-1:0] ar_rem, out_rem, src_rem;
  logic [OW-1:0]          outstanding;
  logic [8:0]             len_beats, ar_step;
  logic                   cmd_fire, ar_fire, r_fire, t_fire, raise, sk_ready;
  logic                   unused_rid;

  assign unused_rid    = ^m_axi_rid;
  assign m_axi_arid    = ID_WIDTH'(ID_VALUE);
  assign m_axi_arsize  = 3'(LSB);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

  // alive keeps the ready outputs low while reset is held
  assign cmd_ready = alive && (state == IDLE);
  assign busy      = (state != IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign ar_fire   = m_axi_arvalid && m_axi_arready;
  assign r_fire    = m_axi_rvalid && m_axi_rready;
  assign t_fire    = m_axis_tvalid && m_axis_tready;
  assign ar_step   = {1'b0, m_axi_arlen} + 9'd1;

  // First burst is sized straight from the command so ARVALID rises one clock after accept
  assign src_addr  = (state == IDLE) ? (cmd_addr & ~ADDR_WIDTH'(BYTES - 1)) : addr_q;
  assign src_rem   = (state == IDLE) ? cmd_beats : ar_rem;
  assign len_beats = burst_beats(src_addr[11:0], 32'(src_rem), 9'(MAX_BURST), LSB);
  assign raise     = (state == IDLE) ? (cmd_fire && cmd_beats != '0)
                   : (state == ADDR && !m_axi_arvalid && ar_rem != '0 &&
                      outstanding < OW'(MAX_OUTSTANDING));

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE:  if (cmd_fire) begin
               if (cmd_beats != '0) state_nx = ADDR;
               else                 done_nx  = 1'b1;
             end
      ADDR:  if (ar_rem == '0) state_nx = DRAIN;
      DRAIN: if (out_rem == '0) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
             end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      alive         <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      addr_q        <= '0;
      ar_rem        <= '0;
      out_rem       <= '0;
      outstanding   <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
    end else begin
      state <= state_nx;
      alive <= 1'b1;
      done  <= done_nx;
      if (cmd_fire) begin
        addr_q  <= src_addr;
        ar_rem  <= cmd_beats;
        out_rem <= cmd_beats;
        err     <= 1'b0;
      end else begin
        if (ar_fire) begin
          addr_q <= addr_q + (ADDR_WIDTH'(ar_step) << LSB);
          ar_rem <= ar_rem - BEATS_WIDTH'(ar_step);
        end
        if (t_fire) out_rem <= out_rem - BEATS_WIDTH'(1);
        if (r_fire && m_axi_rresp != RESP_OKAY) err <= 1'b1;
      end
      if (raise) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= src_addr;
        m_axi_arlen   <= 8'(len_beats - 9'd1);
      end else if (ar_fire) begin
        m_axi_arvalid <= 1'b0;
      end
      case ({ar_fire, r_fire && m_axi_rlast})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  axis_skid_buf #(.WIDTH(DATA_WIDTH)) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .s_data  (m_axi_rdata),
    .s_valid (m_axi_rvalid && alive),
    .s_ready (sk_ready),
    .m_data  (m_axis_tdata),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign m_axi_rready = sk_ready && alive;
  assign m_axis_tlast = m_axis_tvalid && (out_rem == BEATS_WIDTH'(1));

endmodule

// File: tb/tb_axi_mm2s_dma.sv
// Bench for axi_mm2s_dma: throttled AXI memory model plus scoreboards for
// expected AR bursts and AXIS beats, driven by a directed command sequence.
module tb_axi_mm2s_dma;

  logic         clk = 1'b0, rstn = 1'b0;
  logic         cmd_valid, cmd_ready, busy, done, err;
  logic [31:0]  cmd_addr;
  logic [23:0]  cmd_beats;
  logic [5:0]   m_axi_arid, m_axi_rid;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize, m_axi_arprot;
  logic [1:0]   m_axi_arburst, m_axi_rresp;
  logic         m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [3:0]   m_axi_arcache;
  logic [127:0] m_axi_rdata, m_axis_tdata;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;

  always #5 clk = ~clk;

  axi_mm2s_dma dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .busy(busy), .done(done), .err(err),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mdata(input logic [31:0] a);
    return {a, a ^ 32'hA5A5A5A5, ~a, a + 32'h1234};
  endfunction

  typedef struct { logic [127:0] d; logic l; } beat_t;
  beat_t       sb_q[$];
  logic [39:0] exp_ar_q[$];
  logic [39:0] mem_q[$];

  // Expected beats and bursts derived independently from the command
  task automatic push_expect(input logic [31:0] a, input int beats);
    logic [31:0] p;
    int rem, to4k, n;
    p = a & ~32'hF;
    for (int i = 0; i < beats; i++) sb_q.push_back('{mdata(p + 32'(16 * i)), (i == beats - 1)});
    rem = beats;
    while (rem > 0) begin
      to4k = (4096 - int'(p % 4096)) / 16;
      n = rem;
      if (n > 16) n = 16;
      if (n > to4k) n = to4k;
      exp_ar_q.push_back({p, 8'(n - 1)});
      p = p + 32'(16 * n);
      rem -= n;
    end
  endtask

  int r_pct = 100, ar_pct = 100, t_pct = 100, err_beat = -1, r_idx = 0;
  int ar_seen = 0, beats_seen = 0, tlast_seen = 0, done_cnt = 0, outst = 0, max_out = 0;
  int cur_left = 0;
  logic [31:0]  cur_addr;
  logic [39:0]  bq, ar_hold_v;
  logic [128:0] t_hold_v;
  bit rv_hold = 0, ar_hold = 0, t_hold = 0;
  beat_t e;

  // Memory model and monitors: drive at negedge, evaluate the upcoming edge at +1
  always @(negedge clk) begin
    if (!rstn) begin
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
      m_axi_rdata = 0; m_axi_rid = 0; m_axis_tready = 0;
      mem_q.delete(); cur_left = 0; outst = 0;
      rv_hold = 0; ar_hold = 0; t_hold = 0;
    end else begin
      if (!rv_hold) begin
        if (cur_left == 0 && mem_q.size() > 0) begin
          bq = mem_q.pop_front();
          cur_addr = bq[39:8];
          cur_left = int'(bq[7:0]) + 1;
        end
        if (cur_left > 0 && $urandom_range(99, 0) < r_pct) begin
          m_axi_rvalid = 1; m_axi_rdata = mdata(cur_addr); m_axi_rlast = (cur_left == 1);
          m_axi_rresp = (r_idx == err_beat) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 0; m_axi_rlast = 0;
        end
      end
      m_axi_arready = ($urandom_range(99, 0) < ar_pct);
      m_axis_tready = ($urandom_range(99, 0) < t_pct);
      #1;
      if (ar_hold) chk("ar_stable", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, ar_hold_v});
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_ar_q.size() == 0) chk("ar_unexpected", {m_axi_araddr, m_axi_arlen}, 0);
        else begin
          bq = exp_ar_q.pop_front();
          chk("araddr", m_axi_araddr, bq[39:8]);
          chk("arlen", m_axi_arlen, bq[7:0]);
          chk("arsize_burst", {m_axi_arsize, m_axi_arburst}, {3'd4, 2'b01});
        end
        mem_q.push_back({m_axi_araddr, m_axi_arlen});
        ar_seen++; outst++;
      end
      ar_hold = m_axi_arvalid && !m_axi_arready;
      ar_hold_v = {m_axi_araddr, m_axi_arlen};
      if (m_axi_rvalid && m_axi_rready) begin
        rv_hold = 0; cur_addr += 16; cur_left--; r_idx++;
        if (m_axi_rlast) outst--;
      end else rv_hold = m_axi_rvalid;
      if (outst > max_out) max_out = outst;
      if (t_hold) chk("axis_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, t_hold_v});
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb_q.size() == 0) chk("axis_unexpected", m_axis_tdata, 0);
        else begin
          e = sb_q.pop_front();
          chk("tdata", m_axis_tdata, e.d);
          chk("tlast", m_axis_tlast, e.l);
        end
        beats_seen++;
        if (m_axis_tlast) tlast_seen++;
      end
      t_hold = m_axis_tvalid && !m_axis_tready;
      t_hold_v = {m_axis_tlast, m_axis_tdata};
      if (done) done_cnt++;
    end
  end

  task automatic start_cmd(input logic [31:0] a, input int beats);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    r_idx = 0;
    push_expect(a, beats);
    cmd_valid = 1; cmd_addr = a; cmd_beats = 24'(beats);
    @(negedge clk);
    cmd_valid = 0;
    #2;
    if (beats == 0) begin
      chk("done_zero_beats", done, 1);
      chk("cmd_ready_after_zero", cmd_ready, 1);
    end else begin
      chk("arvalid_1clk", m_axi_arvalid, 1);
      chk("busy", busy, 1);
    end
  endtask

  task automatic run_cmd(input logic [31:0] a, input int beats);
    int d0;
    bit ok;
    d0 = done_cnt; ok = 0;
    start_cmd(a, beats);
    for (int i = 0; i < 5000; i++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      @(negedge clk); #2;
    end
    chk("done_seen", ok, 1);
    @(negedge clk); #2;
    chk("done_pulse_1clk", done_cnt - d0, 1);
    chk("done_low", done, 0);
    chk("sb_drained", sb_q.size(), 0);
    chk("ar_q_drained", exp_ar_q.size(), 0);
  endtask

  int a0, b0, l0;

  initial begin
    cmd_valid = 0; cmd_addr = 0; cmd_beats = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
    m_axi_rdata = 0; m_axi_rid = 0; m_axis_tready = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_outputs", {cmd_ready, busy, done, err, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast}, 0);
    chk("rst_payload", {m_axi_araddr, m_axi_arlen, m_axis_tdata[31:0]}, 0);
    @(negedge clk); rstn = 1;
    @(negedge clk); #2;
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // 40 beats at 0x1000: bursts 16/16/8
    r_pct = 70; ar_pct = 70; t_pct = 100;
    a0 = ar_seen; b0 = beats_seen; l0 = tlast_seen;
    run_cmd(32'h1000, 40);
    chk("t1_ar_count", ar_seen - a0, 3);
    chk("t1_beats", beats_seen - b0, 40);
    chk("t1_tlast_count", tlast_seen - l0, 1);
    chk("t1_err", err, 0);
    chk("t1_idle", {busy, cmd_ready}, 2'b01);

    // 4KB split
    a0 = ar_seen; b0 = beats_seen;
    run_cmd(32'h1FC0, 8);
    chk("t2_ar_count", ar_seen - a0, 2);
    chk("t2_beats", beats_seen - b0, 8);

    // zero-beat no-op
    a0 = ar_seen; b0 = beats_seen;
    run_cmd(32'h5000, 0);
    chk("t3_no_ar", ar_seen - a0, 0);
    chk("t3_no_beats", beats_seen - b0, 0);

    // long throttled transfer crossing 4KB
    r_pct = 80; ar_pct = 50; t_pct = 70; max_out = 0;
    b0 = beats_seen;
    run_cmd(32'h3F00, 200);
    chk("t4_beats", beats_seen - b0, 200);
    chk("t4_outstanding_le4", (max_out <= 4), 1);

    // SLVERR on beat 5: sticky err, data still forwarded, cleared by next command
    r_pct = 70; ar_pct = 70; t_pct = 100; err_beat = 5;
    b0 = beats_seen;
    run_cmd(32'h8000, 16);
    chk("t5_beats", beats_seen - b0, 16);
    chk("t5_err_set", err, 1);
    repeat (3) @(negedge clk);
    #2;
    chk("t5_err_sticky", err, 1);
    err_beat = -1;
    run_cmd(32'h8800, 4);
    chk("t5_err_cleared", err, 0);

    // asynchronous reset mid-burst
    r_pct = 100; ar_pct = 100; t_pct = 100;
    start_cmd(32'h9000, 64);
    b0 = beats_seen;
    for (int i = 0; i < 2000 && beats_seen - b0 < 10; i++) @(negedge clk);
    chk("t6_reached_beat10", (beats_seen - b0 >= 10), 1);
    @(posedge clk); #2;
    rstn = 0;
    #1;
    chk("t6_async_outputs", {cmd_ready, busy, done, err, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast}, 0);
    chk("t6_async_payload", {m_axi_araddr, m_axi_arlen, m_axis_tdata[63:0]}, 0);
    sb_q.delete(); exp_ar_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (2) @(negedge clk);
    b0 = beats_seen;
    run_cmd(32'hA000, 20);
    chk("t6_post_reset_beats", beats_seen - b0, 20);
    chk("t6_post_reset_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
